// File: rtl/cgra_config_pkg.sv
// Shared types for the CGRA configuration streamer.
// Holds the FSM state enum, the default entry layout and default widths.
package cgra_config_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 16;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WRITE,
    RD_REQ,
    RD_WAIT,
    GAP,
    DONE
  } state_t;

  typedef struct packed {
    logic                  last;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } entry_t;

endpackage

// File: rtl/cgra_config_loader_if.sv
// Valid/ready stream of (addr, data, last) config words.
// master: host side driving words; slave: loader accepting them.
interface cgra_config_loader_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              s_valid_in;
  logic              s_ready_out;
  logic [ADDR_W-1:0] s_addr_in;
  logic [DATA_W-1:0] s_data_in;
  logic              s_last_in;

  modport master (
    output s_valid_in,
    output s_addr_in,
    output s_data_in,
    output s_last_in,
    input  s_ready_out
  );

  modport slave (
    input  s_valid_in,
    input  s_addr_in,
    input  s_data_in,
    input  s_last_in,
    output s_ready_out
  );
endinterface

// File: rtl/cgra_config_fifo.sv
// Synchronous FIFO, power-of-two DEPTH, registered full/empty flags.
// Ports: clk/rst, push/din, pop/dout (head word), full, empty.
module cgra_config_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    unique case ({do_push, do_pop})
      2'b10:   count_nxt = count + (AW+1)'(1);
      2'b01:   count_nxt = count - (AW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end
endmodule

// File: rtl/cgra_config_loader.sv
// Streams buffered config words onto the CGRA config port.
// Ports: clk_in/reset_in, stream slave s, start/verify, cfg bus, status.
module cgra_config_loader
  import cgra_config_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int GAP_CYCLES = 0,
  parameter int READ_LAT   = 2,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic              clk_in,
  input  logic              reset_in,
  cgra_config_loader_if.slave s,
  input  logic              start_in,
  input  logic              verify_en_in,
  output logic [ADDR_W-1:0] cfg_addr_out,
  output logic [DATA_W-1:0] cfg_data_out,
  output logic              cfg_we_out,
  output logic              cfg_re_out,
  input  logic [DATA_W-1:0] cfg_rdata_in,
  output logic              busy_out,
  output logic              done_out,
  output logic [CNT_W-1:0]  word_count_out,
  output logic [CNT_W-1:0]  err_count_out
);
  localparam int EW = 1 + ADDR_W + DATA_W;
  localparam logic [7:0] GAP_LOAD =
    8'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  localparam logic [7:0] WAIT_LOAD = 8'(READ_LAT - 1);

  state_t          state;
  state_t          after_wr;
  state_t          gap_exit;
  logic            enter_done;
  logic            last_q;
  logic            vfy_q;
  logic [7:0]      gap_cnt;
  logic [7:0]      wait_cnt;
  logic [EW-1:0]   head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;

  assign s.s_ready_out = !fifo_full;
  assign pop = (state == FETCH) && !fifo_empty;

  cgra_config_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_in),
    .rst   (reset_in),
    .push  (s.s_valid_in && s.s_ready_out),
    .din   ({s.s_last_in, s.s_addr_in, s.s_data_in}),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Where a finished word goes next, and whether that lands in DONE
  // this cycle (bus is zeroed and status flips on that same edge).
  always_comb begin
    gap_exit = last_q ? DONE : FETCH;
    after_wr = (GAP_CYCLES > 0) ? GAP : gap_exit;
    if ((state == WRITE && !vfy_q) ||
        (state == RD_WAIT && wait_cnt == 8'd0))
      enter_done = (after_wr == DONE);
    else
      enter_done = (state == GAP) &&
                   (gap_cnt == 8'd0) && last_q;
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state          <= IDLE;
      cfg_addr_out   <= '0;
      cfg_data_out   <= '0;
      cfg_we_out     <= 1'b0;
      cfg_re_out     <= 1'b0;
      busy_out       <= 1'b0;
      done_out       <= 1'b0;
      word_count_out <= '0;
      err_count_out  <= '0;
      last_q         <= 1'b0;
      vfy_q          <= 1'b0;
      gap_cnt        <= '0;
      wait_cnt       <= '0;
    end else begin
      cfg_we_out <= 1'b0;
      cfg_re_out <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start_in) begin
            word_count_out <= '0;
            err_count_out  <= '0;
            done_out       <= 1'b0;
            busy_out       <= 1'b1;
            vfy_q          <= verify_en_in;
            state          <= FETCH;
          end
        end
        FETCH: begin
          if (!fifo_empty) begin
            last_q       <= head[EW-1];
            cfg_addr_out <= head[EW-2:DATA_W];
            cfg_data_out <= head[DATA_W-1:0];
            cfg_we_out   <= 1'b1;
            state        <= WRITE;
          end
        end
        WRITE: begin
          if (word_count_out != '1)
            word_count_out <= word_count_out + CNT_W'(1);
          gap_cnt <= GAP_LOAD;
          if (vfy_q) begin
            cfg_re_out <= 1'b1;
            state      <= RD_REQ;
          end else begin
            state <= after_wr;
          end
        end
        RD_REQ: begin
          wait_cnt <= WAIT_LOAD;
          state    <= RD_WAIT;
        end
        RD_WAIT: begin
          if (wait_cnt == 8'd0) begin
            if (cfg_rdata_in != cfg_data_out &&
                err_count_out != '1)
              err_count_out <= err_count_out + CNT_W'(1);
            gap_cnt <= GAP_LOAD;
            state   <= after_wr;
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end
        GAP: begin
          if (gap_cnt == 8'd0) state <= gap_exit;
          else gap_cnt <= gap_cnt - 8'd1;
        end
        default: state <= IDLE;
      endcase
      if (enter_done) begin
        cfg_addr_out <= '0;
        cfg_data_out <= '0;
        done_out     <= 1'b1;
        busy_out     <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cgra_config_loader.sv
// Directed bench for cgra_config_loader: per-cycle vector tables
// plus sequences for gap, full FIFO, empty-start stall and reset.
module tb_cgra_config_loader;
  import cgra_config_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  cgra_config_loader_if #(.ADDR_W(32), .DATA_W(32)) s0 ();
  cgra_config_loader_if #(.ADDR_W(32), .DATA_W(32)) s1 ();

  logic        start0, vfy0, start1;
  logic [31:0] addr0, data0, rdata0, addr1, data1;
  logic        we0, re0, busy0, done0;
  logic        we1, re1, busy1, done1;
  logic [15:0] wc0, ec0, wc1, ec1;

  cgra_config_loader #(.GAP_CYCLES(0), .READ_LAT(2)) dut0 (
    .clk_in(clk), .reset_in(rst), .s(s0),
    .start_in(start0), .verify_en_in(vfy0),
    .cfg_addr_out(addr0), .cfg_data_out(data0),
    .cfg_we_out(we0), .cfg_re_out(re0),
    .cfg_rdata_in(rdata0),
    .busy_out(busy0), .done_out(done0),
    .word_count_out(wc0), .err_count_out(ec0)
  );

  cgra_config_loader #(.GAP_CYCLES(3), .READ_LAT(2)) dut1 (
    .clk_in(clk), .reset_in(rst), .s(s1),
    .start_in(start1), .verify_en_in(1'b0),
    .cfg_addr_out(addr1), .cfg_data_out(data1),
    .cfg_we_out(we1), .cfg_re_out(re1),
    .cfg_rdata_in(32'h0),
    .busy_out(busy1), .done_out(done1),
    .word_count_out(wc1), .err_count_out(ec1)
  );

  // Readback model: data written is returned, except addr 0x11.
  // Valid only READ_LAT cycles after the read strobe cycle.
  logic [31:0] mem [256];
  logic [31:0] p0 = '0, p1 = '0;
  always @(posedge clk) begin
    if (we0) mem[addr0[7:0]] <= data0;
    if (re0)
      p0 <= (addr0 == 32'h11) ? 32'hFFFF : mem[addr0[7:0]];
    else
      p0 <= '0;
    p1 <= p0;
  end
  assign rdata0 = p1;

  typedef struct {
    logic        start;
    logic        vfy;
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] data;
    logic        busy;
    logic        done;
    logic [15:0] wc;
    logic [15:0] ec;
  } row_t;

  row_t vec [$];

  function automatic row_t r(
    input logic st, input logic vf,
    input logic we, input logic re,
    input logic [31:0] a, input logic [31:0] d,
    input logic bz, input logic dn,
    input logic [15:0] wc, input logic [15:0] ec);
    row_t x;
    x.start = st; x.vfy = vf; x.we = we; x.re = re;
    x.addr = a; x.data = d; x.busy = bz; x.done = dn;
    x.wc = wc; x.ec = ec;
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int w, input entry_t e);
    for (int i = 0; i < 50; i++) begin
      if ((w == 0 ? s0.s_ready_out : s1.s_ready_out)) break;
      tick();
    end
    if (w == 0) begin
      s0.s_valid_in = 1'b1; s0.s_addr_in = e.addr;
      s0.s_data_in = e.data; s0.s_last_in = e.last;
    end else begin
      s1.s_valid_in = 1'b1; s1.s_addr_in = e.addr;
      s1.s_data_in = e.data; s1.s_last_in = e.last;
    end
    tick();
    s0.s_valid_in = 1'b0;
    s1.s_valid_in = 1'b0;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < vec.size(); i++) begin
      start0 = vec[i].start;
      vfy0   = vec[i].vfy;
      chk($sformatf("%s%0d.we", tag, i), 64'(we0), 64'(vec[i].we));
      chk($sformatf("%s%0d.re", tag, i), 64'(re0), 64'(vec[i].re));
      chk($sformatf("%s%0d.addr", tag, i), 64'(addr0),
          64'(vec[i].addr));
      chk($sformatf("%s%0d.data", tag, i), 64'(data0),
          64'(vec[i].data));
      chk($sformatf("%s%0d.busy", tag, i), 64'(busy0),
          64'(vec[i].busy));
      chk($sformatf("%s%0d.done", tag, i), 64'(done0),
          64'(vec[i].done));
      chk($sformatf("%s%0d.wc", tag, i), 64'(wc0), 64'(vec[i].wc));
      chk($sformatf("%s%0d.ec", tag, i), 64'(ec0), 64'(vec[i].ec));
      tick();
    end
    start0 = 1'b0;
    vfy0   = 1'b0;
  endtask

  task automatic push3(input logic [31:0] base);
    entry_t e;
    for (int i = 0; i < 3; i++) begin
      e.addr = base + 32'(i);
      e.data = 32'hA + 32'(i);
      e.last = (i == 2);
      push(0, e);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    entry_t e;
    int weq [$];
    logic [31:0] qa [$];
    logic [31:0] qd [$];
    int rec, done_at, nwe;

    start0 = 0; vfy0 = 0; start1 = 0;
    s0.s_valid_in = 0; s0.s_addr_in = 0;
    s0.s_data_in = 0; s0.s_last_in = 0;
    s1.s_valid_in = 0; s1.s_addr_in = 0;
    s1.s_data_in = 0; s1.s_last_in = 0;
    tick(); tick(); tick();

    chk("rst.we", 64'(we0), 0);
    chk("rst.re", 64'(re0), 0);
    chk("rst.addr", 64'(addr0), 0);
    chk("rst.data", 64'(data0), 0);
    chk("rst.busy", 64'(busy0), 0);
    chk("rst.done", 64'(done0), 0);
    chk("rst.wc", 64'(wc0), 0);
    chk("rst.ec", 64'(ec0), 0);
    chk("rst.busy1", 64'(busy1), 0);
    rst = 1'b0;
    tick();

    // Three words, no verify, no gap.
    push3(32'h10);
    vec.delete();
    vec.push_back(r(1,0, 0,0, 32'h00,32'h0, 0,0, 0,0));
    vec.push_back(r(0,0, 0,0, 32'h00,32'h0, 1,0, 0,0));
    vec.push_back(r(0,0, 1,0, 32'h10,32'hA, 1,0, 0,0));
    vec.push_back(r(0,0, 0,0, 32'h10,32'hA, 1,0, 1,0));
    vec.push_back(r(0,0, 1,0, 32'h11,32'hB, 1,0, 1,0));
    vec.push_back(r(0,0, 0,0, 32'h11,32'hB, 1,0, 2,0));
    vec.push_back(r(0,0, 1,0, 32'h12,32'hC, 1,0, 2,0));
    vec.push_back(r(0,0, 0,0, 32'h00,32'h0, 0,1, 3,0));
    vec.push_back(r(0,0, 0,0, 32'h00,32'h0, 0,1, 3,0));
    run_table("nv");

    // Same words with readback verify; addr 0x11 mismatches.
    push3(32'h10);
    vec.delete();
    vec.push_back(r(1,1, 0,0, 32'h00,32'h0, 0,1, 3,0));
    vec.push_back(r(0,0, 0,0, 32'h00,32'h0, 1,0, 0,0));
    vec.push_back(r(0,0, 1,0, 32'h10,32'hA, 1,0, 0,0));
    vec.push_back(r(0,0, 0,1, 32'h10,32'hA, 1,0, 1,0));
    vec.push_back(r(0,0, 0,0, 32'h10,32'hA, 1,0, 1,0));
    vec.push_back(r(0,0, 0,0, 32'h10,32'hA, 1,0, 1,0));
    vec.push_back(r(0,0, 0,0, 32'h10,32'hA, 1,0, 1,0));
    vec.push_back(r(0,0, 1,0, 32'h11,32'hB, 1,0, 1,0));
    vec.push_back(r(0,0, 0,1, 32'h11,32'hB, 1,0, 2,0));
    vec.push_back(r(0,0, 0,0, 32'h11,32'hB, 1,0, 2,0));
    vec.push_back(r(0,0, 0,0, 32'h11,32'hB, 1,0, 2,0));
    vec.push_back(r(0,0, 0,0, 32'h11,32'hB, 1,0, 2,1));
    vec.push_back(r(0,0, 1,0, 32'h12,32'hC, 1,0, 2,1));
    vec.push_back(r(0,0, 0,1, 32'h12,32'hC, 1,0, 3,1));
    vec.push_back(r(0,0, 0,0, 32'h12,32'hC, 1,0, 3,1));
    vec.push_back(r(0,0, 0,0, 32'h12,32'hC, 1,0, 3,1));
    vec.push_back(r(0,0, 0,0, 32'h00,32'h0, 0,1, 3,1));
    run_table("vf");

    // GAP_CYCLES=3 on dut1: strobes 5 cycles apart.
    e.addr = 32'h20; e.data = 32'h1; e.last = 0; push(1, e);
    e.addr = 32'h21; e.data = 32'h2; e.last = 1; push(1, e);
    rec = 0; done_at = -1;
    for (int c = 0; c < 13; c++) begin
      start1 = (c == 0);
      if (we1) weq.push_back(c);
      if (re1) rec++;
      if (done1 && done_at < 0) done_at = c;
      tick();
    end
    start1 = 0;
    chk("gap.nwe", 64'(weq.size()), 2);
    chk("gap.we0", 64'(weq.size() > 0 ? weq[0] : -1), 2);
    chk("gap.we1", 64'(weq.size() > 1 ? weq[1] : -1), 7);
    chk("gap.re", 64'(rec), 0);
    chk("gap.done", 64'(done_at), 11);
    chk("gap.wc", 64'(wc1), 2);

    // Fill FIFO to 16 without start; 17th is refused.
    for (int i = 0; i < 16; i++) begin
      e.addr = 32'h100 + 32'(i);
      e.data = 32'h5000 + 32'(i);
      e.last = (i == 15);
      push(0, e);
    end
    chk("full.ready", 64'(s0.s_ready_out), 0);
    s0.s_valid_in = 1; s0.s_addr_in = 32'h1FF;
    s0.s_data_in = 32'hDEAD; s0.s_last_in = 1;
    tick();
    s0.s_valid_in = 0;
    chk("full.ready17", 64'(s0.s_ready_out), 0);
    for (int c = 0; c < 80; c++) begin
      start0 = (c == 0);
      if (we0) begin
        qa.push_back(addr0);
        qd.push_back(data0);
      end
      if (c > 0 && done0) break;
      tick();
    end
    start0 = 0;
    chk("full.done", 64'(done0), 1);
    chk("full.n", 64'(qa.size()), 16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("full.a%0d", i),
          64'(i < qa.size() ? qa[i] : 32'hFFFF_FFFF),
          64'(32'h100 + 32'(i)));
      chk($sformatf("full.d%0d", i),
          64'(i < qd.size() ? qd[i] : 32'hFFFF_FFFF),
          64'(32'h5000 + 32'(i)));
    end
    chk("full.wc", 64'(wc0), 16);
    chk("full.ready_after", 64'(s0.s_ready_out), 1);

    // Start with empty FIFO; word arrives 5 cycles later.
    start0 = 1;
    tick();
    start0 = 0;
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("stall.busy%0d", c), 64'(busy0), 1);
      chk($sformatf("stall.we%0d", c), 64'(we0), 0);
      tick();
    end
    chk("stall.busy5", 64'(busy0), 1);
    e.addr = 32'h30; e.data = 32'h33; e.last = 1;
    push(0, e);
    chk("stall.we6", 64'(we0), 0);
    tick();
    chk("stall.we7", 64'(we0), 1);
    chk("stall.addr7", 64'(addr0), 32'h30);
    chk("stall.data7", 64'(data0), 32'h33);
    tick();
    chk("stall.done8", 64'(done0), 1);
    chk("stall.wc8", 64'(wc0), 1);

    // Reset between 2nd and 3rd write.
    push3(32'h40);
    start0 = 1;
    tick();
    start0 = 0;
    tick(); tick(); tick();
    chk("mid.we4", 64'(we0), 1);
    chk("mid.addr4", 64'(addr0), 32'h41);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("mid.we", 64'(we0), 0);
    chk("mid.re", 64'(re0), 0);
    chk("mid.addr", 64'(addr0), 0);
    chk("mid.data", 64'(data0), 0);
    chk("mid.busy", 64'(busy0), 0);
    chk("mid.done", 64'(done0), 0);
    chk("mid.wc", 64'(wc0), 0);
    chk("mid.ec", 64'(ec0), 0);
    tick();
    rst = 1'b0;
    tick();
    start0 = 1;
    tick();
    start0 = 0;
    nwe = 0;
    for (int c = 0; c < 10; c++) begin
      if (we0) nwe++;
      tick();
    end
    chk("post.nwe", 64'(nwe), 0);
    chk("post.busy", 64'(busy0), 1);
    chk("post.wc", 64'(wc0), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
